// File: rtl/seg_scan_scheduler.sv
// -----------------------------------------------------------------------------
// seg_scan_scheduler
//   Scan controller for an 8-digit seven-segment display. A CPU write path and
//   an 8-bit switch-echo path feed a double-buffered 32-bit display value.
//   A new value is only loaded at a frame boundary, which is the start of
//   digit 0, so a digit is never torn mid-scan. A tick-driven FSM alternates
//   BLANK and DRIVE slots and produces one-hot digit enables and segment codes.
//
// Optional feature macro: SEG_LEADING_ZERO_BLANK_EN
//   When it is defined, digits above the most significant nonzero nibble stay
//   dark during their DRIVE slot. Slot timing does not change. Digit 0 is
//   always shown.
//
// Ports
//   clk          system clock
//   rst          asynchronous active-high reset
//   switch_en    1 = show the switch echo; overrides the CPU source
//   sw_data[7:0] switch value for echo mode
//   cpu_wr       single-cycle CPU write strobe
//   cpu_wdata    CPU display value, 8 hex nibbles, digit 0 = [3:0]
//   cpu_wr_ack   one-cycle acknowledge of cpu_wr
//   frame_start  one-cycle pulse when a new frame value is loaded
//   an[7:0]      one-hot digit enable, active-high, an[i] = digit i
//   seg[7:0]     segment code for digits 4-7 (bit7 = a ... bit0 = dp)
//   seg1[7:0]    segment code for digits 0-3
// -----------------------------------------------------------------------------
module seg_scan_scheduler #(
    parameter int TICK_DIV    = 50000,
    parameter int DRIVE_TICKS = 2,
    parameter int BLANK_TICKS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        switch_en,
    input  logic [7:0]  sw_data,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_wr_ack,
    output logic        frame_start,
    output logic [7:0]  an,
    output logic [7:0]  seg,
    output logic [7:0]  seg1
);

    localparam int TW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int ST_MAX = (DRIVE_TICKS > BLANK_TICKS) ? DRIVE_TICKS : BLANK_TICKS;
    localparam int SW     = (ST_MAX > 1) ? $clog2(ST_MAX) : 1;

    typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

    state_t          r_state;
    logic [TW-1:0]   r_tick_cnt;
    logic [SW-1:0]   r_st_cnt;
    logic [2:0]      r_digit_idx;
    logic [31:0]     r_pending_buf;
    logic            r_pending_vld;
    logic [31:0]     r_frame_buf;
    logic            r_cpu_wr_ack;
    logic            r_frame_start;
    logic [7:0]      r_an;
    logic [7:0]      r_seg;
    logic [7:0]      r_seg1;

    logic            w_tick;
    logic            w_last_blank;
    logic            w_boundary;
    logic [2:0]      w_idx_next;
    logic [15:0]     w_sw_exp;
    logic [31:0]     w_frame_next;
    logic [3:0]      w_nibble;
    logic [7:0]      w_code;
    logic            w_show;

    function automatic logic [7:0] seg_code(input logic [3:0] nib);
        case (nib)
            4'h0: seg_code = 8'hFC;
            4'h1: seg_code = 8'h60;
            4'h2: seg_code = 8'hDA;
            4'h3: seg_code = 8'hF2;
            4'h4: seg_code = 8'h66;
            4'h5: seg_code = 8'hB6;
            4'h6: seg_code = 8'hBE;
            4'h7: seg_code = 8'hE0;
            4'h8: seg_code = 8'hFE;
            4'h9: seg_code = 8'hF6;
            4'hA: seg_code = 8'hEE;
            4'hB: seg_code = 8'h3E;
            4'hC: seg_code = 8'h9C;
            4'hD: seg_code = 8'h7A;
            4'hE: seg_code = 8'h9E;
            default: seg_code = 8'h8E;
        endcase
    endfunction

    assign w_tick       = (r_tick_cnt == TW'(TICK_DIV - 1));
    assign w_last_blank = (r_state == ST_BLANK) && w_tick && (r_st_cnt == SW'(BLANK_TICKS - 1));
    assign w_idx_next   = r_digit_idx + 3'd1;
    // Wrapping from digit 7 to digit 0 marks the frame boundary.
    assign w_boundary   = w_last_blank && (r_digit_idx == 3'd7);

    // Each switch bit is drawn as two adjacent display bits.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_sw_exp
            assign w_sw_exp[2*gi +: 2] = {2{sw_data[gi]}};
        end
    endgenerate

    // Value that frame_buf holds after this edge. The segment lookup also uses
    // it, so digit 0 of a new frame shows the new value at once.
    always_comb begin
        w_frame_next = r_frame_buf;
        if (w_boundary) begin
            if (switch_en)
                w_frame_next = {16'h0000, w_sw_exp};
            else if (r_pending_vld)
                w_frame_next = r_pending_buf;
        end
    end

    assign w_nibble = w_frame_next[{w_idx_next, 2'b00} +: 4];
    assign w_code   = seg_code(w_nibble);

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic [2:0] w_msd;
    always_comb begin
        w_msd = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (w_frame_next[4*i +: 4] != 4'h0)
                w_msd = 3'(i);
        end
    end
    assign w_show = (w_idx_next <= w_msd);
`else
    assign w_show = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_BLANK;
            r_tick_cnt    <= '0;
            r_st_cnt      <= '0;
            r_digit_idx   <= 3'd7;
            r_pending_buf <= '0;
            r_pending_vld <= 1'b0;
            r_frame_buf   <= '0;
            r_cpu_wr_ack  <= 1'b0;
            r_frame_start <= 1'b0;
            r_an          <= '0;
            r_seg         <= '0;
            r_seg1        <= '0;
        end else begin
            r_tick_cnt    <= w_tick ? '0 : r_tick_cnt + 1'b1;
            r_cpu_wr_ack  <= cpu_wr;
            r_frame_start <= w_boundary;
            r_frame_buf   <= w_frame_next;

            // A write in the boundary cycle lands in pending after the
            // boundary has consumed the old pending value.
            if (w_boundary && !switch_en && r_pending_vld)
                r_pending_vld <= 1'b0;
            if (cpu_wr) begin
                r_pending_buf <= cpu_wdata;
                r_pending_vld <= 1'b1;
            end

            case (r_state)
                ST_BLANK: begin
                    if (w_tick) begin
                        if (w_last_blank) begin
                            r_st_cnt    <= '0;
                            r_state     <= ST_DRIVE;
                            r_digit_idx <= w_idx_next;
                            if (w_show) begin
                                r_an   <= 8'b1 << w_idx_next;
                                r_seg  <= w_idx_next[2] ? w_code : 8'h00;
                                r_seg1 <= w_idx_next[2] ? 8'h00 : w_code;
                            end else begin
                                r_an   <= '0;
                                r_seg  <= '0;
                                r_seg1 <= '0;
                            end
                        end else begin
                            r_st_cnt <= r_st_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    if (w_tick) begin
                        if (r_st_cnt == SW'(DRIVE_TICKS - 1)) begin
                            r_st_cnt <= '0;
                            r_state  <= ST_BLANK;
                            r_an     <= '0;
                            r_seg    <= '0;
                            r_seg1   <= '0;
                        end else begin
                            r_st_cnt <= r_st_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign cpu_wr_ack  = r_cpu_wr_ack;
    assign frame_start = r_frame_start;
    assign an          = r_an;
    assign seg         = r_seg;
    assign seg1        = r_seg1;

endmodule

// File: tb/tb_seg_scan_scheduler.sv
module tb_seg_scan_scheduler;

    localparam int TD = 4;
    localparam int DT = 2;
    localparam int BT = 1;
    localparam int S  = DT + BT;

    localparam logic [7:0] SEGT [0:15] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
        8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        switch_en = 1'b0;
    logic [7:0]  sw_data = 8'h00;
    logic        cpu_wr = 1'b0;
    logic [31:0] cpu_wdata = 32'h0;
    logic        cpu_wr_ack;
    logic        frame_start;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic [7:0]  seg1;

    seg_scan_scheduler #(
        .TICK_DIV(TD), .DRIVE_TICKS(DT), .BLANK_TICKS(BT)
    ) dut (
        .clk(clk), .rst(rst), .switch_en(switch_en), .sw_data(sw_data),
        .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata), .cpu_wr_ack(cpu_wr_ack),
        .frame_start(frame_start), .an(an), .seg(seg), .seg1(seg1)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Behavioural model: position in the scan is derived from the number of
    // clock edges since reset release.
    int          m_e = 0;
    logic [31:0] m_pend = 0, m_frame = 0;
    bit          m_pvld = 0;
    logic [7:0]  m_an = 0, m_seg = 0, m_seg1 = 0;
    bit          m_ack = 0, m_fs = 0;

    function automatic int msd(input logic [31:0] v);
        int r = 0;
        for (int i = 1; i < 8; i++) if (v[4*i +: 4] != 4'h0) r = i;
        return r;
    endfunction

    function automatic logic [31:0] expand(input logic [7:0] s);
        logic [31:0] r = 32'h0;
        for (int i = 0; i < 8; i++) r[2*i +: 2] = {2{s[i]}};
        return r;
    endfunction

    task automatic model_edge();
        int n, m, d;
        logic [3:0] nib;
        bit show;
        if (rst) begin
            m_e = 0; m_pend = 0; m_pvld = 0; m_frame = 0;
            m_an = 0; m_seg = 0; m_seg1 = 0; m_ack = 0; m_fs = 0;
            return;
        end
        m_ack = cpu_wr;
        m_fs  = 0;
        if (m_e % TD == TD - 1) begin
            n = (m_e + 1) / TD;
            m = n % S;
            d = (n / S) % 8;
            if (m == BT) begin
                if (d == 0) begin
                    m_fs = 1;
                    if (switch_en) m_frame = expand(sw_data);
                    else if (m_pvld) begin m_frame = m_pend; m_pvld = 0; end
                end
                nib  = m_frame[4*d +: 4];
                show = 1;
`ifdef SEG_LEADING_ZERO_BLANK_EN
                show = (d <= msd(m_frame));
`endif
                m_an   = show ? 8'(1 << d) : 8'h00;
                m_seg  = (show && d >= 4) ? SEGT[nib] : 8'h00;
                m_seg1 = (show && d < 4)  ? SEGT[nib] : 8'h00;
            end else if (m == 0) begin
                m_an = 0; m_seg = 0; m_seg1 = 0;
            end
        end
        if (cpu_wr) begin m_pend = cpu_wdata; m_pvld = 1; end
        m_e++;
    endtask

    // One clock cycle: advance the model, clock the DUT, compare all outputs.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        tests++;
        if (an !== m_an || seg !== m_seg || seg1 !== m_seg1 ||
            cpu_wr_ack !== m_ack || frame_start !== m_fs) begin
            fails++;
            $display("FAIL model cyc=%0d got an=%h seg=%h seg1=%h ack=%b fs=%b want an=%h seg=%h seg1=%h ack=%b fs=%b",
                     cyc, an, seg, seg1, cpu_wr_ack, frame_start,
                     m_an, m_seg, m_seg1, m_ack, m_fs);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end else
            $display("[TB] %s ok value=%h", name, act);
    endtask

    task automatic wait_an(input logic [7:0] want);
        int k = 0;
        while (an !== want && k < 300) begin step(); k++; end
        if (an !== want) begin
            tests++; fails++;
            $display("FAIL wait_an timeout got=%h want=%h", an, want);
        end
    endtask

    task automatic wait_fs();
        int k = 0;
        step();
        while (frame_start !== 1'b1 && k < 300) begin step(); k++; end
        if (frame_start !== 1'b1) begin
            tests++; fails++;
            $display("FAIL wait_fs timeout got=%b want=1", frame_start);
        end
    endtask

    task automatic write(input logic [31:0] v);
        cpu_wr = 1; cpu_wdata = v;
        step();
        cpu_wr = 0;
        chk("wr_ack", {31'h0, cpu_wr_ack}, 32'h1);
    endtask

    localparam logic [7:0] EXP_89 [0:7] = '{8'h8E, 8'h9E, 8'h7A, 8'h9C, 8'h3E, 8'hEE, 8'hF6, 8'hFE};
    localparam logic [7:0] EXP_SW [0:7] = '{8'hF2, 8'hF2, 8'h9C, 8'h9C, 8'hFC, 8'hFC, 8'hFC, 8'hFC};

    initial begin
        int k;
        int nd;
        bit bad;
        // reset held
        step(); step();
        chk("reset_an", {24'h0, an}, 32'h0);
        chk("reset_segs", {16'h0, seg, seg1}, 32'h0);
        rst = 0;
        k = 0;
        while (an === 8'h00 && k < 20) begin step(); k++; end
        chk("first_drive_cycles", k, 4);
        chk("first_an", {24'h0, an}, 32'h01);
        chk("first_seg1", {24'h0, seg1}, 32'hFC);
        chk("first_seg", {24'h0, seg}, 32'h00);
        chk("first_fs", {31'h0, frame_start}, 32'h1);

        // CPU write mid-frame
        wait_an(8'h08);
        write(32'h89ABCDEF);
        wait_fs();
        for (int d = 0; d < 8; d++) begin
            wait_an(8'(1 << d));
            chk($sformatf("cpu_digit%0d", d), {24'h0, (d < 4) ? seg1 : seg}, {24'h0, EXP_89[d]});
        end

        // switch echo
        switch_en = 1; sw_data = 8'hA5;
        wait_fs();
`ifdef SEG_LEADING_ZERO_BLANK_EN
        nd = 4;
`else
        nd = 8;
`endif
        for (int d = 0; d < nd; d++) begin
            wait_an(8'(1 << d));
            chk($sformatf("sw_digit%0d", d), {24'h0, (d < 4) ? seg1 : seg}, {24'h0, EXP_SW[d]});
        end

        // write while switch echo active
        write(32'h11111111);
        wait_fs();
        chk("sw_persist", {24'h0, seg1}, 32'hF2);
        wait_an(8'h04);
        switch_en = 0;
        wait_fs();
        for (int d = 0; d < 8; d++) begin
            wait_an(8'(1 << d));
            chk($sformatf("ones_digit%0d", d), {24'h0, (d < 4) ? seg1 : seg}, 32'h60);
        end

        // two writes in one frame: last one wins
        wait_an(8'h04);
        write(32'h1);
        write(32'h2);
        wait_fs();
        chk("last_wins", {24'h0, seg1}, 32'hDA);

        // reset mid-DRIVE with a pending write
        write(32'h77777777);
        wait_an(8'h02);
        rst = 1;
        #1;
        chk("async_rst_out", {an, seg, seg1}, 32'h0);
        step(); step();
        rst = 0;
        wait_fs();
        chk("rst_pending_lost", {24'h0, seg1}, 32'hFC);

`ifdef SEG_LEADING_ZERO_BLANK_EN
        write(32'h00000305);
        wait_fs();
        bad = 0;
        for (int i = 0; i < 8 * S * TD; i++) begin
            step();
            if (!(an inside {8'h00, 8'h01, 8'h02, 8'h04})) bad = 1;
        end
        chk("lz_305_digits", {31'h0, bad}, 32'h0);
        write(32'h0);
        wait_fs();
        chk("lz_zero_seg1", {24'h0, seg1}, 32'hFC);
        bad = 0;
        for (int i = 0; i < 8 * S * TD; i++) begin
            step();
            if (!(an inside {8'h00, 8'h01})) bad = 1;
        end
        chk("lz_zero_digits", {31'h0, bad}, 32'h0);
`endif

        // randomized traffic checked against the model every cycle
        for (int i = 0; i < 2500; i++) begin
            cpu_wr = ($urandom_range(0, 24) == 0);
            cpu_wdata = $urandom >> (4 * $urandom_range(0, 7));
            if ($urandom_range(0, 199) == 0) begin
                switch_en = ~switch_en;
                sw_data = 8'($urandom);
            end
            step();
        end
        cpu_wr = 0;
        switch_en = 0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
